// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one imem read per PC value, at most one request
// outstanding. Fetched words go to decode through a registered output stage
// backed by a single skid entry. Branch/jump redirects take priority over
// everything else.
// Optional feature: define IFU_MISALIGN_TRAP_EN to trap misaligned PCs
// (FAULT state, if_exc). When it is undefined, pc[1:0] is ignored and if_exc
// is tied low.
//
// state | meaning
// IDLE  | just out of reset, moves to REQ on the next edge
// REQ   | presenting a request for pc
// WAIT  | request accepted, response owed (discard set: drop it)
// HOLD  | output and skid both full, waiting for decode to consume
// FAULT | misaligned pc reported, waiting for a redirect (trap build only)
module instr_fetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_exc,
  input  logic        id_ready
);

`ifdef IFU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD, ST_FAULT} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} state_t;
`endif

  state_t      state;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        discard;
  logic [31:0] req_pc;
  logic        misaligned;
  logic        accept;
  logic        consume;
  logic        redirect_act;

`ifdef IFU_MISALIGN_TRAP_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
  assign if_exc     = 1'b0;
`endif

  // Request handshake, decode handshake and next-PC selection
  assign redirect_act   = redirect_valid && (state != ST_IDLE);
  assign imem_req_valid = (state == ST_REQ) && !redirect_valid && !misaligned;
  assign imem_req_addr  = {pc[31:2], 2'b00};
  assign accept         = imem_req_valid && imem_req_ready;
  assign consume        = if_valid && id_ready;
  assign next_pc        = redirect_act ? redirect_pc :
                          accept       ? pc + PC_STEP : pc;

  // Fetch FSM with output stage and skid; later assignments override earlier ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= NOP_INSTR;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
      discard    <= 1'b0;
      req_pc     <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
      if_exc     <= 1'b0;
`endif
    end else begin
      // Decode took the output: refill from skid or go empty
      if (consume) begin
        if (skid_valid) begin
          if_pc      <= skid_pc;
          if_instr   <= skid_instr;
          skid_valid <= 1'b0;
        end else begin
          if_valid <= 1'b0;
          if_instr <= NOP_INSTR;
        end
`ifdef IFU_MISALIGN_TRAP_EN
        if_exc <= 1'b0;
`endif
      end

      if (redirect_act) begin
        if_valid   <= 1'b0;
        if_instr   <= NOP_INSTR;
        skid_valid <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        if_exc     <= 1'b0;
`endif
        // A response still owed from memory must be swallowed before refetching
        if (state == ST_WAIT && !imem_rsp_valid) begin
          discard <= 1'b1;
          state   <= ST_WAIT;
        end else begin
          discard <= 1'b0;
          state   <= ST_REQ;
        end
      end else begin
        case (state)
          ST_IDLE: state <= ST_REQ;
          ST_REQ: begin
            if (misaligned) begin
`ifdef IFU_MISALIGN_TRAP_EN
              if_valid <= 1'b1;
              if_exc   <= 1'b1;
              if_pc    <= pc;
              if_instr <= NOP_INSTR;
              state    <= ST_FAULT;
`endif
            end else if (accept) begin
              req_pc <= imem_req_addr;
              state  <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (imem_rsp_valid) begin
              if (discard) begin
                discard <= 1'b0;
                state   <= ST_REQ;
              end else if (!if_valid || consume) begin
                if_valid <= 1'b1;
                if_pc    <= req_pc;
                if_instr <= imem_rsp_data;
                state    <= ST_REQ;
              end else begin
                skid_valid <= 1'b1;
                skid_pc    <= req_pc;
                skid_instr <= imem_rsp_data;
                state      <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (consume) state <= ST_REQ;
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
